res_station: RTL and testbench
==============================

// Module: res_station
// PURPOSE
//  Unified reservation station between rename and the back-end scheduler. Allocates a slot per renamed uop,
//  captures operand values broadcast at retire (tag = producer ROB address) and exposes all slots via 4
//  combinational read ports to the scheduler. Frees a slot on scheduler issue; clears everything on flush.
// PARAMETERS
//  RES_ST_DEPTH  16  number of slots; power of two, >=4; res_st_addr_t is $clog2(RES_ST_DEPTH) bits
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  flush        in   1       mispredicted-branch flush; same effect as rst on slot state
//  wr_en        in   1       allocate: write wr_cell into lowest free slot
//  wr_cell      in   cell    res_st_cell_t from rename; bit 0 = valid
//  full         out  1       all slots valid; rename must not assert wr_en
//  rdN_addr     in   addr    N=1..4, scheduler read address
//  rdN_data     out  cell    N=1..4, slot contents, combinational from rdN_addr
//  iss_en       in   1       scheduler issued slot iss_addr; free it
//  iss_addr     in   addr    slot being issued
//  ret_en       in   1       retire broadcast valid
//  ret_rob_addr in   rob     ROB address of retiring producer
//  ret_value    in   32      result value of retiring producer
// BEHAVIOUR
//  - Cell fields: valid, uop, pc, imm, rob_addr, dest phy_rf_addr, src1/src2 {rdy, rob_tag, value}.
//  - Reset/flush: every slot valid=0 next edge; full=0; rdN_data of a cleared slot has valid=0.
//    flush has priority over wr_en/iss_en/ret_en in the same cycle.
//  - Allocation: wr_en && !full writes the lowest-index slot with valid=0; visible on rdN_data next cycle.
//    wr_en while full: ignored, no state change. full is registered state decoded (all valid), 0-cycle.
//  - Issue: iss_en clears valid of iss_addr next edge; iss_en on an invalid slot is harmless.
//    iss_en + wr_en same cycle: freed slot is NOT reused that cycle (allocation sees pre-edge valid).
//  - Wakeup: on ret_en, each valid slot with srcX.rdy=0 and srcX.rob_tag==ret_rob_addr sets rdy=1 and
//    value=ret_value next edge. src1 and src2 checked independently (both may wake together).
//  - Write/wakeup collision: wr_cell operands are compared against the same-cycle broadcast before being
//    stored, so a producer retiring in the allocation cycle wakes the new slot (no lost wakeup).
//  - Slot freed by iss_en in same cycle as a matching broadcast: free wins, no wakeup recorded.
//  - Read ports never stall; same address on several ports returns identical data.
// CONFIGURATION
//  QU_RES_ST_OCC_EN defined: adds port occupancy out $clog2(RES_ST_DEPTH)+1 bits, registered count of
//    valid slots; updates +1 on accepted write, -1 on issue of a valid slot, net 0 when both; 0 on rst/flush.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  qu_common package: RES_ST_DEPTH, res_st_addr_t, res_st_cell_t, rob_addr_t, phy_rf_addr_t.
//  Sub-module res_st_alloc: combinational priority encoder over valid vector -> {free_addr, any_free}.
//  Slot storage is a flop array (multi-port read + broadcast compare rules out RAM inference).
// TESTING
//  1 rst, then 16 wr_en with distinct rob_addr -> slots 0..15 valid in order, full=1 after 16th edge.
//  2 full, wr_en with rob_addr=0x3F -> ignored, no slot contains 0x3F; iss_en addr 5 -> full=0 next cycle,
//    next write lands in slot 5.
//  3 slot 2 src1 tag 7 not ready; ret_en rob 7 value 0xDEADBEEF -> slot 2 src1 rdy=1, value 0xDEADBEEF;
//    slots with other tags unchanged; src2 tag 7 in slot 4 also woken same edge.
//  4 wr_en cell src2 tag 9 rdy=0 with ret_en rob 9 value 0x12345678 same cycle -> stored src2 rdy=1,
//    value 0x12345678.
//  5 8 slots valid, flush asserted together with wr_en and ret_en -> all valid=0, full=0, occupancy=0
//    (when QU_RES_ST_OCC_EN).
//  6 iss_en slot 3 and ret_en matching slot 3 tag same cycle -> slot 3 invalid; later write to slot 3 holds
//    only wr_cell data.

Source files
------------

// File: rtl/res_station_pkg.sv
// Shared types for the unified reservation station.
// Holds the slot count, address/tag widths, the slot cell layout (bit 0 = valid)
// and the operand wakeup helper used by both stored slots and the incoming cell.
package res_station_pkg;

    localparam int unsigned RES_ST_DEPTH  = 16;
    localparam int unsigned RES_ST_ADDR_W = $clog2(RES_ST_DEPTH);
    localparam int unsigned RES_ST_OCC_W  = RES_ST_ADDR_W + 1;
    localparam int unsigned ROB_ADDR_W    = 6;
    localparam int unsigned PHY_RF_ADDR_W = 6;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned UOP_W         = 8;

    typedef logic [RES_ST_ADDR_W-1:0] res_st_addr_t;
    typedef logic [ROB_ADDR_W-1:0]    rob_addr_t;
    typedef logic [PHY_RF_ADDR_W-1:0] phy_rf_addr_t;

    typedef struct packed {
        logic            rdy;
        rob_addr_t       rob_tag;
        logic [XLEN-1:0] value;
    } res_st_src_t;

    // valid is the last field so it lands on bit 0
    typedef struct packed {
        res_st_src_t        src2;
        res_st_src_t        src1;
        phy_rf_addr_t       dest;
        rob_addr_t          rob_addr;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic [UOP_W-1:0]   uop;
        logic               valid;
    } res_st_cell_t;

    // Capture a retire broadcast into a waiting operand
    function automatic res_st_src_t src_wake(res_st_src_t src, logic en,
                                             rob_addr_t tag, logic [XLEN-1:0] value);
        res_st_src_t r;
        r = src;
        if (en && !src.rdy && (src.rob_tag == tag)) begin
            r.rdy   = 1'b1;
            r.value = value;
        end
        return r;
    endfunction

endpackage

// File: rtl/res_station_if.sv
// Rename/scheduler/retire bundle of the reservation station.
// master: rename + scheduler + retire side; slave: the reservation station.
// Optional occupancy output exists only when QU_RES_ST_OCC_EN is defined.
interface res_station_if;
    import res_station_pkg::*;

    logic         flush;
    logic         wr_en;
    res_st_cell_t wr_cell;
    logic         full;
    res_st_addr_t rd1_addr;
    res_st_addr_t rd2_addr;
    res_st_addr_t rd3_addr;
    res_st_addr_t rd4_addr;
    res_st_cell_t rd1_data;
    res_st_cell_t rd2_data;
    res_st_cell_t rd3_data;
    res_st_cell_t rd4_data;
    logic         iss_en;
    res_st_addr_t iss_addr;
    logic         ret_en;
    rob_addr_t    ret_rob_addr;
    logic [XLEN-1:0] ret_value;
`ifdef QU_RES_ST_OCC_EN
    logic [RES_ST_OCC_W-1:0] occupancy;
`endif

    modport master (
        output flush, wr_en, wr_cell, rd1_addr, rd2_addr, rd3_addr, rd4_addr,
               iss_en, iss_addr, ret_en, ret_rob_addr, ret_value,
`ifdef QU_RES_ST_OCC_EN
        input  occupancy,
`endif
        input  full, rd1_data, rd2_data, rd3_data, rd4_data
    );

    modport slave (
        input  flush, wr_en, wr_cell, rd1_addr, rd2_addr, rd3_addr, rd4_addr,
               iss_en, iss_addr, ret_en, ret_rob_addr, ret_value,
`ifdef QU_RES_ST_OCC_EN
        output occupancy,
`endif
        output full, rd1_data, rd2_data, rd3_data, rd4_data
    );

endinterface

// File: rtl/res_station_alloc.sv
// res_st_alloc: lowest-index free slot finder over the valid vector.
// Ports: valid (in, one bit per slot), free_addr (out, lowest slot with valid=0),
//        any_free (out, at least one slot free).
module res_st_alloc
    import res_station_pkg::*;
(
    input  logic [RES_ST_DEPTH-1:0] valid,
    output res_st_addr_t            free_addr,
    output logic                    any_free
);

    // Scan high to low so the lowest free index is the last one written
    always_comb begin
        free_addr = '0;
        any_free  = 1'b0;
        for (int i = RES_ST_DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_addr = res_st_addr_t'(i);
                any_free  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/res_station.sv
// res_station: unified reservation station between rename and the scheduler.
// Ports: clk, rst (synchronous, active-high), rs (res_station_if.slave):
//   flush/wr_en/wr_cell/full for allocation, rd1..rd4 addr/data combinational
//   read ports, iss_en/iss_addr to free a slot, ret_en/ret_rob_addr/ret_value
//   retire broadcast for operand wakeup.
// Optional feature: define QU_RES_ST_OCC_EN to add rs.occupancy (valid slot count).
module res_station
    import res_station_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    res_station_if.slave rs
);

    res_st_cell_t              slots_q [RES_ST_DEPTH];
    logic [RES_ST_DEPTH-1:0]   valid_vec;
    res_st_addr_t              free_addr;
    logic                      any_free;
    logic                      wr_take_c;
    res_st_cell_t              wr_cell_c;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            valid_vec[i] = slots_q[i].valid;
        end
    end

    res_st_alloc u_alloc (
        .valid     (valid_vec),
        .free_addr (free_addr),
        .any_free  (any_free)
    );

    assign wr_take_c = rs.wr_en && any_free;

    // Incoming cell sees the same-cycle broadcast so a producer retiring now is not missed
    always_comb begin
        wr_cell_c       = rs.wr_cell;
        wr_cell_c.valid = 1'b1;
        wr_cell_c.src1  = src_wake(rs.wr_cell.src1, rs.ret_en, rs.ret_rob_addr, rs.ret_value);
        wr_cell_c.src2  = src_wake(rs.wr_cell.src2, rs.ret_en, rs.ret_rob_addr, rs.ret_value);
    end

    // Slot storage: only valid is reset; payload is don't-care while invalid.
    // Allocation only targets invalid slots, so it safely outranks a same-slot issue.
    // Issue outranks wakeup so a freed slot records nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            if (rst || rs.flush) begin
                slots_q[i].valid <= 1'b0;
            end else if (wr_take_c && (free_addr == res_st_addr_t'(i))) begin
                slots_q[i] <= wr_cell_c;
            end else if (rs.iss_en && (rs.iss_addr == res_st_addr_t'(i))) begin
                slots_q[i].valid <= 1'b0;
            end else if (slots_q[i].valid) begin
                slots_q[i].src1 <= src_wake(slots_q[i].src1, rs.ret_en, rs.ret_rob_addr, rs.ret_value);
                slots_q[i].src2 <= src_wake(slots_q[i].src2, rs.ret_en, rs.ret_rob_addr, rs.ret_value);
            end
        end
    end

    assign rs.full     = !any_free;
    assign rs.rd1_data = slots_q[rs.rd1_addr];
    assign rs.rd2_data = slots_q[rs.rd2_addr];
    assign rs.rd3_data = slots_q[rs.rd3_addr];
    assign rs.rd4_data = slots_q[rs.rd4_addr];

`ifdef QU_RES_ST_OCC_EN
    logic [RES_ST_OCC_W-1:0] occ_q;
    logic                    iss_dec_c;

    assign iss_dec_c = rs.iss_en && valid_vec[rs.iss_addr];

    // Count of valid slots; write and issue in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (rst || rs.flush) begin
            occ_q <= '0;
        end else if (wr_take_c && !iss_dec_c) begin
            occ_q <= occ_q + RES_ST_OCC_W'(1);
        end else if (!wr_take_c && iss_dec_c) begin
            occ_q <= occ_q - RES_ST_OCC_W'(1);
        end
    end

    assign rs.occupancy = occ_q;
`endif

endmodule

// File: tb/tb_res_station.sv
module tb_res_station;
    import res_station_pkg::*;

    localparam int K_VALID = 0;
    localparam int K_FULL  = 1;
    localparam int K_ROB   = 2;
    localparam int K_S1RDY = 3;
    localparam int K_S1VAL = 4;
    localparam int K_S2RDY = 5;
    localparam int K_S2VAL = 6;
    localparam int K_OCC   = 7;

    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] exp;
    } item_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    item_t exp_q[$];

    res_station_if rs ();

    res_station dut (
        .clk (clk),
        .rst (rst),
        .rs  (rs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string kname(int k);
        case (k)
            K_VALID: return "valid";
            K_FULL:  return "full";
            K_ROB:   return "rob_addr";
            K_S1RDY: return "src1_rdy";
            K_S1VAL: return "src1_value";
            K_S2RDY: return "src2_rdy";
            K_S2VAL: return "src2_value";
            K_OCC:   return "occupancy";
            default: return "unknown";
        endcase
    endfunction

    function automatic res_st_cell_t mk(int i, rob_addr_t rob);
        res_st_cell_t c;
        c            = '0;
        c.valid      = 1'b1;
        c.uop        = UOP_W'(i);
        c.pc         = 32'(32'h1000 + 4 * i);
        c.imm        = 32'(i);
        c.rob_addr   = rob;
        c.dest       = PHY_RF_ADDR_W'(i);
        c.src1.rdy   = 1'b1;
        c.src1.value = 32'(i);
        c.src2.rdy   = 1'b1;
        return c;
    endfunction

    // Monitor: one expected item per falling edge, read through the ports
    initial begin
        item_t        it;
        res_st_cell_t c;
        logic [31:0]  act;
        logic         ok;
        rs.rd1_addr = '0;
        rs.rd2_addr = '0;
        rs.rd3_addr = '0;
        rs.rd4_addr = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                rs.rd1_addr = res_st_addr_t'(it.addr);
                rs.rd2_addr = res_st_addr_t'(it.addr);
                rs.rd3_addr = res_st_addr_t'(it.addr);
                rs.rd4_addr = res_st_addr_t'(it.addr);
                #1;
                c  = rs.rd1_data;
                ok = 1'b1;
                case (it.kind)
                    K_VALID: act = 32'(c.valid);
                    K_FULL:  act = 32'(rs.full);
                    K_ROB: begin
                        act = 32'(c.rob_addr);
                        ok  = (rs.rd2_data == c) && (rs.rd3_data == c) && (rs.rd4_data == c);
                    end
                    K_S1RDY: act = 32'(c.src1.rdy);
                    K_S1VAL: act = c.src1.value;
                    K_S2RDY: act = 32'(c.src2.rdy);
                    K_S2VAL: act = c.src2.value;
`ifdef QU_RES_ST_OCC_EN
                    K_OCC:   act = 32'(rs.occupancy);
`endif
                    default: act = 32'hFFFF_FFFF;
                endcase
                n_chk++;
                if (!ok || (act !== it.exp)) begin
                    n_fail++;
                    $display("FAIL %s slot %0d: got 0x%0h, expected 0x%0h%s", kname(it.kind),
                             it.addr, act, it.exp, ok ? "" : " (read ports disagree)");
                end
            end
        end
    end

    task automatic idle();
        rs.flush        = 1'b0;
        rs.wr_en        = 1'b0;
        rs.iss_en       = 1'b0;
        rs.ret_en       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_v(int kind, int addr, logic [31:0] exp);
        item_t it;
        it.kind = kind;
        it.addr = addr;
        it.exp  = exp;
        exp_q.push_back(it);
    endtask

    task automatic expect_occ(int n);
`ifdef QU_RES_ST_OCC_EN
        expect_v(K_OCC, 0, 32'(n));
`else
        if (n < 0) $display("negative occupancy request %0d", n);
`endif
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d items pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic write(res_st_cell_t c);
        rs.wr_en   = 1'b1;
        rs.wr_cell = c;
        tick();
    endtask

    task automatic issue(int a);
        rs.iss_en   = 1'b1;
        rs.iss_addr = res_st_addr_t'(a);
        tick();
    endtask

    initial begin
        res_st_cell_t c;
        n_chk  = 0;
        n_fail = 0;
        idle();
        rs.wr_cell      = '0;
        rs.iss_addr     = '0;
        rs.ret_rob_addr = '0;
        rs.ret_value    = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        expect_v(K_VALID, 0, 0);
        expect_v(K_VALID, 15, 0);
        expect_v(K_FULL, 0, 0);
        expect_occ(0);
        drain();

        // fill all 16 slots in order
        for (int i = 0; i < 16; i++) begin
            c = mk(i, rob_addr_t'(8'h10 + i));
            if (i == 2) begin c.src1.rdy = 1'b0; c.src1.rob_tag = 6'd7;  c.src1.value = '0; end
            if (i == 3) begin c.src1.rdy = 1'b0; c.src1.rob_tag = 6'h0B; c.src1.value = '0; end
            if (i == 4) begin c.src2.rdy = 1'b0; c.src2.rob_tag = 6'd7; end
            if (i == 6) begin c.src1.rdy = 1'b0; c.src1.rob_tag = 6'd8;  c.src1.value = 32'h66; end
            write(c);
            if (i == 14) begin
                expect_v(K_FULL, 0, 0);
                expect_v(K_VALID, 15, 0);
                drain();
            end
        end
        expect_v(K_FULL, 0, 1);
        expect_v(K_ROB, 0, 32'h10);
        expect_v(K_ROB, 7, 32'h17);
        expect_v(K_VALID, 15, 1);
        expect_occ(16);
        drain();

        // write while full is ignored
        write(mk(0, 6'h3F));
        for (int i = 0; i < 16; i++) expect_v(K_ROB, i, 32'(8'h10 + i));
        expect_v(K_FULL, 0, 1);
        expect_occ(16);
        drain();

        // issue slot 5, then the next write refills slot 5
        issue(5);
        expect_v(K_FULL, 0, 0);
        expect_v(K_VALID, 5, 0);
        expect_occ(15);
        drain();
        write(mk(5, 6'h25));
        expect_v(K_VALID, 5, 1);
        expect_v(K_ROB, 5, 32'h25);
        expect_v(K_FULL, 0, 1);
        drain();

        // retire broadcast wakes tag 7 in slot 2 src1 and slot 4 src2
        rs.ret_en = 1'b1; rs.ret_rob_addr = 6'd7; rs.ret_value = 32'hDEADBEEF;
        tick();
        expect_v(K_S1RDY, 2, 1);
        expect_v(K_S1VAL, 2, 32'hDEADBEEF);
        expect_v(K_S2RDY, 4, 1);
        expect_v(K_S2VAL, 4, 32'hDEADBEEF);
        expect_v(K_S1RDY, 6, 0);
        expect_v(K_S1VAL, 6, 32'h66);
        expect_v(K_S1RDY, 3, 0);
        expect_v(K_S1VAL, 4, 32'd4);
        drain();

        // allocation in the same cycle as a matching broadcast
        issue(0);
        c = mk(0, 6'h30);
        c.src1.value = 32'hAA;
        c.src2.rdy = 1'b0; c.src2.rob_tag = 6'd9;
        rs.ret_en = 1'b1; rs.ret_rob_addr = 6'd9; rs.ret_value = 32'h12345678;
        write(c);
        expect_v(K_ROB, 0, 32'h30);
        expect_v(K_S2RDY, 0, 1);
        expect_v(K_S2VAL, 0, 32'h12345678);
        expect_v(K_S1VAL, 0, 32'hAA);
        expect_occ(16);
        drain();

        // issue and matching broadcast on slot 3 in the same cycle: free wins
        rs.ret_en = 1'b1; rs.ret_rob_addr = 6'h0B; rs.ret_value = 32'hCAFEF00D;
        issue(3);
        expect_v(K_VALID, 3, 0);
        expect_v(K_S1RDY, 3, 0);
        expect_occ(15);
        drain();
        c = mk(3, 6'h33);
        c.src1.rdy = 1'b0; c.src1.rob_tag = 6'h0B; c.src1.value = '0;
        write(c);
        expect_v(K_VALID, 3, 1);
        expect_v(K_ROB, 3, 32'h33);
        expect_v(K_S1RDY, 3, 0);
        expect_v(K_S1VAL, 3, 0);
        drain();

        // drop to 8 valid, then flush with write and broadcast together
        for (int i = 8; i < 16; i++) issue(i);
        expect_occ(8);
        expect_v(K_FULL, 0, 0);
        expect_v(K_VALID, 8, 0);
        expect_v(K_VALID, 7, 1);
        drain();
        rs.flush = 1'b1;
        rs.ret_en = 1'b1; rs.ret_rob_addr = 6'd8; rs.ret_value = 32'h1;
        write(mk(0, 6'h3E));
        expect_v(K_VALID, 0, 0);
        expect_v(K_VALID, 3, 0);
        expect_v(K_VALID, 7, 0);
        expect_v(K_VALID, 8, 0);
        expect_v(K_FULL, 0, 0);
        expect_occ(0);
        drain();

        // slot freed by issue is not reused in the same cycle
        write(mk(0, 6'h01));
        write(mk(1, 6'h02));
        rs.iss_en = 1'b1; rs.iss_addr = 4'd0;
        write(mk(2, 6'h03));
        expect_v(K_VALID, 0, 0);
        expect_v(K_VALID, 1, 1);
        expect_v(K_VALID, 2, 1);
        expect_v(K_ROB, 2, 32'h03);
        expect_occ(2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
